// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the packet buffer read path: default widths, read FSM
// state encoding and the circular-pointer increment.
package pkt_buf_pkg;

    localparam int DATA_WIDTH         = 8;
    localparam int MAX_PACKET_LENGHT  = 1536;
    localparam int DEPTH_RAM          = 2 * MAX_PACKET_LENGHT;
    localparam int LEN_WIDTH          = $clog2(MAX_PACKET_LENGHT + 1);
    localparam int ADDR_WIDTH         = $clog2(DEPTH_RAM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN,
        ST_GAP
    } rd_state_e;

    // Depth need not be a power of two, so the wrap is explicit.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pkt_read_ctrl_if.sv
// Bus bundle between the read controller (master) and its environment: length
// FIFO, RAM read port, transmit stream and release/status reporting.
interface pkt_read_ctrl_if
    import pkt_buf_pkg::*;
#(
    parameter int pDATA_WIDTH = DATA_WIDTH,
    parameter int pLEN_WIDTH  = LEN_WIDTH,
    parameter int pADDR_WIDTH = ADDR_WIDTH
);
    logic                   i_len_empty;
    logic [pLEN_WIDTH-1:0]  i_len_data;
    logic                   o_len_rd;
    logic [pADDR_WIDTH-1:0] o_ram_raddr;
    logic [pDATA_WIDTH-1:0] i_ram_rdata;
    logic [pDATA_WIDTH-1:0] o_tx_d;
    logic                   o_tx_dv;
    logic                   o_tx_last;
    logic                   i_tx_ready;
    logic                   o_rel_valid;
    logic [pLEN_WIDTH-1:0]  o_rel_len;
    logic                   o_len_err;
    logic                   o_busy;

    modport master (
        input  i_len_empty, i_len_data, i_ram_rdata, i_tx_ready,
        output o_len_rd, o_ram_raddr, o_tx_d, o_tx_dv, o_tx_last,
               o_rel_valid, o_rel_len, o_len_err, o_busy
    );

    modport slave (
        output i_len_empty, i_len_data, i_ram_rdata, i_tx_ready,
        input  o_len_rd, o_ram_raddr, o_tx_d, o_tx_dv, o_tx_last,
               o_rel_valid, o_rel_len, o_len_err, o_busy
    );

endinterface

// File: rtl/pkt_rd_skid.sv
// Two-entry {last, data} buffer between the RAM return path and the tx stream.
// Head entry is a flop, so output stays stable while the sink stalls.
module pkt_rd_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         o_vld,
    output logic [W-1:0] o_data,
    output logic         o_last,
    output logic [1:0]   o_occ
);
    typedef struct packed {
        logic         last;
        logic [W-1:0] data;
    } entry_t;

    entry_t     mem_q [2];
    entry_t     mem_d [2];
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = '{last: push_last, data: push_data};
            wr_d        = ~wr_q;
        end
        if (pop) rd_d = ~rd_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    assign o_vld  = (cnt_q != 2'd0);
    assign o_data = mem_q[rd_q].data;
    assign o_last = mem_q[rd_q].last;
    assign o_occ  = cnt_q;

endmodule

// File: rtl/pkt_read_ctrl.sv
// Packet buffer read controller: pops length descriptors, walks the circular
// RAM read pointer and streams bytes out. Optional gap: PKT_READ_CTRL_IFG_EN.
module pkt_read_ctrl
    import pkt_buf_pkg::*;
#(
    parameter int pDATA_WIDTH        = DATA_WIDTH,
    parameter int pMAX_PACKET_LENGHT = MAX_PACKET_LENGHT,
    parameter int pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
    parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT + 1),
    parameter int pADDR_WIDTH        = $clog2(pDEPTH_RAM)
`ifdef PKT_READ_CTRL_IFG_EN
    ,
    parameter int pIFG_CYCLES        = 12
`endif
) (
    input  logic           iclk,
    input  logic           i_rst_n,
    pkt_read_ctrl_if.master bus
);
    rd_state_e              state_q, state_d;
    logic [pADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [pLEN_WIDTH-1:0]  rem_q, rem_d;
    logic [pLEN_WIDTH-1:0]  pkt_len_q, pkt_len_d;
    logic                   infl_q, infl_d;
    logic                   infl_last_q, infl_last_d;
    logic                   len_rd_q, len_rd_d;
    logic                   rel_valid_q, rel_valid_d;
    logic [pLEN_WIDTH-1:0]  rel_len_q, rel_len_d;
    logic                   len_err_q, len_err_d;
    logic                   busy_q, busy_d;
`ifdef PKT_READ_CTRL_IFG_EN
    localparam int GAP_W = $clog2(pIFG_CYCLES + 1);
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
`endif

    logic                   skid_vld;
    logic                   skid_last;
    logic [1:0]             skid_occ;
    logic                   pop;
    logic [2:0]             occ_eff;
    logic                   issue;

    pkt_rd_skid #(.W(pDATA_WIDTH)) u_skid (
        .clk       (iclk),
        .rst_n     (i_rst_n),
        .push      (infl_q),
        .push_data (bus.i_ram_rdata),
        .push_last (infl_last_q),
        .pop       (pop),
        .o_vld     (skid_vld),
        .o_data    (bus.o_tx_d),
        .o_last    (skid_last),
        .o_occ     (skid_occ)
    );

    // Counting this cycle's pop lets a new read issue while a byte leaves,
    // which is what keeps a ready-high stream free of bubbles.
    assign pop     = skid_vld & bus.i_tx_ready;
    assign occ_eff = {1'b0, skid_occ} + {2'b0, infl_q} - {2'b0, pop};
    assign issue   = (state_q == ST_STREAM) && (occ_eff < 3'd2);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        pkt_len_d   = pkt_len_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        len_rd_d    = 1'b0;
        rel_valid_d = 1'b0;
        rel_len_d   = '0;
        len_err_d   = 1'b0;
`ifdef PKT_READ_CTRL_IFG_EN
        gap_cnt_d   = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.i_len_empty) begin
                    state_d  = ST_LOAD;
                    len_rd_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.i_len_data == '0 ||
                    bus.i_len_data > pLEN_WIDTH'(pMAX_PACKET_LENGHT)) begin
                    len_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    rem_d     = bus.i_len_data;
                    pkt_len_d = bus.i_len_data;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (issue) begin
                    ptr_d       = pADDR_WIDTH'(ptr_wrap_inc(32'(ptr_q), pDEPTH_RAM));
                    rem_d       = rem_q - pLEN_WIDTH'(1);
                    infl_d      = 1'b1;
                    infl_last_d = (rem_q == pLEN_WIDTH'(1));
                    if (rem_q == pLEN_WIDTH'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && skid_last) begin
                    rel_valid_d = 1'b1;
                    rel_len_d   = pkt_len_q;
`ifdef PKT_READ_CTRL_IFG_EN
                    gap_cnt_d   = '0;
                    state_d     = ST_GAP;
`else
                    state_d     = ST_IDLE;
`endif
                end
            end
`ifdef PKT_READ_CTRL_IFG_EN
            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(pIFG_CYCLES - 1)) state_d = ST_IDLE;
                else gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            pkt_len_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            len_rd_q    <= 1'b0;
            rel_valid_q <= 1'b0;
            rel_len_q   <= '0;
            len_err_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef PKT_READ_CTRL_IFG_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            pkt_len_q   <= pkt_len_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            len_rd_q    <= len_rd_d;
            rel_valid_q <= rel_valid_d;
            rel_len_q   <= rel_len_d;
            len_err_q   <= len_err_d;
            busy_q      <= busy_d;
`ifdef PKT_READ_CTRL_IFG_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign bus.o_len_rd    = len_rd_q;
    assign bus.o_ram_raddr = ptr_q;
    assign bus.o_tx_dv     = skid_vld;
    assign bus.o_tx_last   = skid_vld & skid_last;
    assign bus.o_rel_valid = rel_valid_q;
    assign bus.o_rel_len   = rel_len_q;
    assign bus.o_len_err   = len_err_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: doc/pkt_read_ctrl.md
# pkt_read_ctrl

Read-side controller for the shared packet buffer (byte-wide register-file RAM plus packet-length FIFO filled by the receive write path). Pops one length descriptor at a time, walks the circular RAM read pointer over that packet, and streams bytes out on a ready/valid transmit interface with full throughput and backpressure. On completion it reports released space to the write side and optionally enforces an inter-packet gap.

## Interface
- pDATA_WIDTH, 8, byte width of RAM and tx stream
- pMAX_PACKET_LENGHT, 1536, largest legal packet in bytes
- pDEPTH_RAM, 2*pMAX_PACKET_LENGHT, RAM depth in bytes
- pLEN_WIDTH, $clog2(pMAX_PACKET_LENGHT+1), length descriptor width
- pADDR_WIDTH, $clog2(pDEPTH_RAM), RAM address width
- pIFG_CYCLES, 12, gap cycles after each packet (used only with IFG feature)

- iclk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_len_empty  in  1  length FIFO empty
- i_len_data  in  pLEN_WIDTH  length FIFO head (first-word-fall-through)
- o_len_rd  out  1  pop length FIFO, one-cycle pulse
- o_ram_raddr  out  pADDR_WIDTH  RAM read address; data returns on i_ram_rdata next cycle
- i_ram_rdata  in  pDATA_WIDTH  RAM read data
- o_tx_d  out  pDATA_WIDTH  output byte
- o_tx_dv  out  1  output byte valid
- o_tx_last  out  1  marks final byte of packet, qualified by o_tx_dv
- i_tx_ready  in  1  sink accepts byte when o_tx_dv & i_tx_ready
- o_rel_valid  out  1  one-cycle pulse: packet fully sent, space released
- o_rel_len  out  pLEN_WIDTH  bytes released, valid with o_rel_valid
- o_len_err  out  1  one-cycle pulse: illegal descriptor discarded
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, STREAM, DRAIN, GAP.
- IDLE: if !i_len_empty -> LOAD.
- LOAD: o_len_rd=1; latch i_len_data into remaining-count and packet length. Length 0 or > pMAX_PACKET_LENGHT: pulse o_len_err, pointer unchanged, -> IDLE. Else -> STREAM.
- STREAM: issue one address per cycle while (buffer occupancy + reads in flight) < 2; after each issue pointer+1, wrapping pDEPTH_RAM-1 -> 0; remaining-1. Remaining reaches 0 -> DRAIN.
- DRAIN: wait until byte tagged last is accepted; then o_rel_valid=1, o_rel_len=packet length; -> GAP (feature on) or IDLE.
- GAP: count pIFG_CYCLES cycles, then -> IDLE.
- Last-byte tag travels with the byte through the buffer; o_tx_last=1 only on that byte.
- o_tx_d/o_tx_last stable while o_tx_dv & !i_tx_ready.
- Pointer persists across packets; never resets except by i_rst_n.

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE, pointer 0, buffer empty; all outputs 0 (o_ram_raddr=0).
- i_len_empty falls in cycle t (IDLE): LOAD/o_len_rd at t+1, first address t+2, data on i_ram_rdata t+3, o_tx_dv first high t+4.
- i_tx_ready held high: one byte per cycle, no bubbles inside a packet.
- Packet length N, ready high: last byte at t+3+N; o_rel_valid in the cycle after last acceptance.
- Backpressure: issue stops when 2 bytes held/in flight; no byte lost or duplicated; resumes cycle after i_tx_ready returns.
- i_len_empty ignored outside IDLE; descriptors arriving mid-packet wait.
- Reset mid-packet: packet abandoned, no o_rel_valid.

## Configuration
- PKT_READ_CTRL_IFG_EN defined: GAP state present, o_tx_dv low for pIFG_CYCLES cycles after each o_rel_valid before next LOAD.
- Undefined: DRAIN -> IDLE directly; GAP logic and counter absent; pIFG_CYCLES unused.

## Structure
- Shared package pkt_buf_pkg: state enumeration, default widths (pLEN_WIDTH, pADDR_WIDTH derivations), pointer-wrap increment function.
- Sub-module pkt_rd_skid: 2-entry buffer of {last, data} with push from RAM return and pop on o_tx_dv & i_tx_ready, exposing occupancy.

## Test plan
- Single descriptor 64, ready high -> 64 bytes from addresses 0..63, o_tx_last on byte 64, o_rel_valid with o_rel_len=64, pointer 64.
- Pointer at 3060, descriptor 20 -> addresses 3060..3071 then 0..7, data order preserved.
- Descriptor 100, i_tx_ready toggling 1/0 every cycle -> exactly 100 bytes, in order, each held stable while not ready.
- Descriptors 0 and 2000 -> two o_len_err pulses, two pops, no o_tx_dv, pointer unchanged.
- Two queued descriptors 64,64 with IFG enabled -> 12 idle cycles between o_rel_valid and next o_len_rd+3; disabled -> no GAP cycles.
- i_rst_n asserted at byte 30 of 64 -> all outputs 0 immediately, pointer 0, no o_rel_valid.
